uldl_tdd_scheduler: RTL and testbench
=====================================

// Module: uldl_tdd_scheduler
// PURPOSE
//   Downstream of traffic_uldl_core: consumes its packet events (id, direction, pulse) and queues
//   them in separate uplink and downlink FIFOs. A TDD frame FSM alternates UL and DL transmit slots
//   separated by guard intervals. Packets drain through a valid/ready TX port, only in their slot.
// PARAMETERS
//   DEPTH      4   entries per direction FIFO (power of 2, >=2)
//   GUARD_CYC  1   guard-interval length in cycles (>=1)
// PORTS
//   clk             in   1  global clock
//   rst_n           in   1  asynchronous active-low reset
//   ena             in   1  block enable; low freezes all state
//   i_packet_id     in   8  packet id from core
//   i_dir_dl        in   1  packet direction (0=UL, 1=DL)
//   i_packet_pulse  in   1  one-cycle packet-available strobe
//   i_slot_len      in   4  slot length minus 1 (slot = i_slot_len+1 cycles, 1..16)
//   i_tx_ready      in   1  sink ready
//   o_tx_valid      out  1  TX packet valid
//   o_tx_id         out  8  TX packet id (FIFO head)
//   o_tx_dir_dl     out  1  direction of TX packet (= o_slot_dl)
//   o_slot_dl       out  1  1 during DL slot or the guard that follows it
//   o_in_guard      out  1  1 during guard intervals
//   o_ul_count      out  3  UL FIFO occupancy (0..DEPTH)
//   o_dl_count      out  3  DL FIFO occupancy (0..DEPTH)
//   o_drop_cnt      out  8  dropped-packet counter (ULDL_DROP_CNT_EN only)
// BEHAVIOUR
//   - Reset: FIFOs empty, state UL_SLOT, slot cnt 0, slot_len latched as 0 (reset slot = 1 cycle).
//     Reset outputs: o_tx_valid=0, o_tx_id=0, o_tx_dir_dl=0, o_slot_dl=0, o_in_guard=0,
//     o_ul_count=0, o_dl_count=0, o_drop_cnt=0. Reset mid-transfer discards all queued packets.
//   - FSM: UL_SLOT -> GUARD_UD -> DL_SLOT -> GUARD_DU -> UL_SLOT.
//     Slot state lasts latched_len+1 cycles. latched_len = i_slot_len, sampled on the cycle a slot
//     state is entered. Guard states last GUARD_CYC cycles.
//   - Push: ena & i_packet_pulse writes i_packet_id to the FIFO selected by i_dir_dl at next edge.
//     Push to a full FIFO is dropped, unless that same FIFO pops in the same cycle. In that case
//     the push is accepted and the count is unchanged.
//   - o_tx_valid (combinational) = ena & in-slot & current-slot FIFO non-empty; 0 in guards.
//     o_tx_id = current-slot FIFO head; it holds 0 when o_tx_valid=0.
//   - Pop on o_tx_valid & i_tx_ready; o_tx_id advances to the next entry on the following cycle.
//   - Slot-bounded: an offer not accepted by the last slot cycle is withdrawn (valid->0 in guard).
//     The packet stays at the FIFO head for that direction's next slot; it is never lost.
//   - Push and pop on the same FIFO in one cycle, non-full: both happen, count unchanged.
//     Same cycle on different FIFOs: independent.
//   - Pointers wrap modulo DEPTH; counts saturate at DEPTH, never wrap.
//   - ena low: FSM, slot counter, FIFOs frozen; pulses ignored, not counted as drops; o_tx_valid=0.
// CONFIGURATION
//   ULDL_DROP_CNT_EN defined: o_drop_cnt increments on every dropped push.
//     The counter saturates at 255 and is cleared only by reset.
//   ULDL_DROP_CNT_EN undefined: o_drop_cnt is tied to 0 and no counter flops exist.
// TESTING
//   - Reset, ena=1, slot_len=3, no pulses: states cycle UL(1 reset slot),G(1),DL(4),G(1),UL(4).
//     o_tx_valid stays 0 throughout.
//   - Push UL ids 0x11,0x22,0x33, ready=1: each id emitted in order, one per cycle, in UL slot.
//     None emitted in DL slot or guard; o_ul_count returns to 0.
//   - Push 6 DL packets (DEPTH=4) during UL slot: o_dl_count=4, o_drop_cnt=2 (macro on).
//     With the macro off, o_drop_cnt stays 0.
//   - DL head 0x5A, ready=0 across whole DL slot: valid drops in guard, o_dl_count unchanged.
//     Next DL slot, ready=1: 0x5A emitted first.
//   - DL FIFO full, DL pulse id 0x77 while DL pop accepted: count stays 4, no drop.
//     0x77 emitted last.
//   - ena=0 for 5 cycles mid-slot with pulses: slot cnt, counts, o_drop_cnt unchanged, valid=0.
//     Slot resumes exactly where it stopped.
//   - Assert rst_n low mid-DL-slot with 3 queued: all outputs at reset values immediately (async).

Source files
------------

// File: rtl/uldl_tdd_scheduler.sv
// uldl_tdd_scheduler: UL/DL packet FIFOs drained through a valid/ready port in alternating TDD slots.
// Optional drop counter is built when ULDL_DROP_CNT_EN is defined.
`default_nettype none

module uldl_tdd_scheduler #(
  parameter int DEPTH     = 4,
  parameter int GUARD_CYC = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [7:0] i_packet_id,
  input  logic       i_dir_dl,
  input  logic       i_packet_pulse,
  input  logic [3:0] i_slot_len,
  input  logic       i_tx_ready,
  output logic       o_tx_valid,
  output logic [7:0] o_tx_id,
  output logic       o_tx_dir_dl,
  output logic       o_slot_dl,
  output logic       o_in_guard,
  output logic [2:0] o_ul_count,
  output logic [2:0] o_dl_count,
  output logic [7:0] o_drop_cnt
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int GW = (GUARD_CYC > 1) ? $clog2(GUARD_CYC) : 1;
  localparam int CW = (GW > 4) ? GW : 4;
  localparam logic [2:0]    FULL_CNT   = 3'(DEPTH);
  localparam logic [CW-1:0] GUARD_LAST = CW'(GUARD_CYC - 1);

  typedef enum logic [1:0] {
    UL_SLOT  = 2'd0,
    GUARD_UD = 2'd1,
    DL_SLOT  = 2'd2,
    GUARD_DU = 2'd3
  } state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic [3:0]    len_q, len_nxt;
  logic          in_slot, slot_dl, in_guard;

  logic [1:0]      push_req, push_ok, pop, full, nonempty;
  logic [1:0][7:0] head;
  logic [1:0][2:0] fifo_cnt;
  logic            cur;
  logic            tx_valid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= UL_SLOT;
      cnt   <= '0;
      len_q <= 4'd0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      len_q <= len_nxt;
    end
  end

  // The slot length is captured as a slot is entered so a mid-slot change cannot stretch it.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    len_nxt   = len_q;
    in_slot   = 1'b0;
    slot_dl   = 1'b0;
    in_guard  = 1'b0;
    unique case (state)
      UL_SLOT: begin
        in_slot = 1'b1;
        if (ena) begin
          if (cnt == CW'(len_q)) begin
            state_nxt = GUARD_UD;
            cnt_nxt   = '0;
          end else begin
            cnt_nxt = cnt + CW'(1);
          end
        end
      end
      GUARD_UD: begin
        in_guard = 1'b1;
        if (ena) begin
          if (cnt == GUARD_LAST) begin
            state_nxt = DL_SLOT;
            cnt_nxt   = '0;
            len_nxt   = i_slot_len;
          end else begin
            cnt_nxt = cnt + CW'(1);
          end
        end
      end
      DL_SLOT: begin
        in_slot = 1'b1;
        slot_dl = 1'b1;
        if (ena) begin
          if (cnt == CW'(len_q)) begin
            state_nxt = GUARD_DU;
            cnt_nxt   = '0;
          end else begin
            cnt_nxt = cnt + CW'(1);
          end
        end
      end
      GUARD_DU: begin
        in_guard = 1'b1;
        slot_dl  = 1'b1;
        if (ena) begin
          if (cnt == GUARD_LAST) begin
            state_nxt = UL_SLOT;
            cnt_nxt   = '0;
            len_nxt   = i_slot_len;
          end else begin
            cnt_nxt = cnt + CW'(1);
          end
        end
      end
      default: ;
    endcase
  end

  assign cur      = slot_dl;
  assign tx_valid = ena & in_slot & nonempty[cur];
  assign push_req = {ena & i_packet_pulse & i_dir_dl, ena & i_packet_pulse & ~i_dir_dl};
  assign pop      = {tx_valid & i_tx_ready & cur, tx_valid & i_tx_ready & ~cur};
  // A full FIFO still accepts a push when its head leaves in the same cycle.
  assign push_ok  = push_req & (~full | pop);

  for (genvar g = 0; g < 2; g++) begin : g_fifo
    logic [7:0]    mem [DEPTH];
    logic [PW-1:0] wr_ptr, rd_ptr;
    logic [2:0]    occ;

    always_ff @(posedge clk) begin
      if (push_ok[g]) mem[wr_ptr] <= i_packet_id;
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        occ    <= 3'd0;
      end else begin
        if (push_ok[g]) wr_ptr <= wr_ptr + PW'(1);
        if (pop[g])     rd_ptr <= rd_ptr + PW'(1);
        if (push_ok[g] && !pop[g])      occ <= occ + 3'd1;
        else if (!push_ok[g] && pop[g]) occ <= occ - 3'd1;
      end
    end

    assign head[g]     = mem[rd_ptr];
    assign fifo_cnt[g] = occ;
    assign full[g]     = (occ == FULL_CNT);
    assign nonempty[g] = (occ != 3'd0);
  end

`ifdef ULDL_DROP_CNT_EN
  logic       drop;
  logic [7:0] drop_cnt;

  assign drop = |(push_req & ~push_ok);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                          drop_cnt <= 8'd0;
    else if (drop && drop_cnt != 8'hFF) drop_cnt <= drop_cnt + 8'd1;
  end

  assign o_drop_cnt = drop_cnt;
`else
  assign o_drop_cnt = 8'd0;
`endif

  assign o_tx_valid  = tx_valid;
  assign o_tx_id     = tx_valid ? head[cur] : 8'h00;
  assign o_tx_dir_dl = slot_dl;
  assign o_slot_dl   = slot_dl;
  assign o_in_guard  = in_guard;
  assign o_ul_count  = fifo_cnt[0];
  assign o_dl_count  = fifo_cnt[1];

endmodule

`default_nettype wire

// File: tb/tb_uldl_tdd_scheduler.sv
// Bench for uldl_tdd_scheduler: vector table, directed corner sequences and random traffic vs a queue model.
`default_nettype none

module tb_uldl_tdd_scheduler;
  localparam int DEPTH     = 4;
  localparam int GUARD_CYC = 1;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       ena = 1'b0;
  logic [7:0] packet_id = 8'h00;
  logic       dir_dl = 1'b0;
  logic       packet_pulse = 1'b0;
  logic [3:0] slot_len = 4'd3;
  logic       tx_ready = 1'b0;
  logic       tx_valid, tx_dir_dl, slot_dl, in_guard;
  logic [7:0] tx_id, drop_cnt;
  logic [2:0] ul_count, dl_count;

  uldl_tdd_scheduler #(.DEPTH(DEPTH), .GUARD_CYC(GUARD_CYC)) dut (
    .clk(clk), .rst_n(rst_n), .ena(ena),
    .i_packet_id(packet_id), .i_dir_dl(dir_dl), .i_packet_pulse(packet_pulse),
    .i_slot_len(slot_len), .i_tx_ready(tx_ready),
    .o_tx_valid(tx_valid), .o_tx_id(tx_id), .o_tx_dir_dl(tx_dir_dl),
    .o_slot_dl(slot_dl), .o_in_guard(in_guard),
    .o_ul_count(ul_count), .o_dl_count(dl_count), .o_drop_cnt(drop_cnt)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Reference model: phase 0=UL slot, 1=guard, 2=DL slot, 3=guard; remain = cycles left in phase.
  int         m_phase = 0;
  int         m_remain = 1;
  int         m_len = 0;
  int         m_drops = 0;
  logic [7:0] q_ul[$];
  logic [7:0] q_dl[$];
  logic [7:0] dut_dl_emit[$];

  function automatic bit m_valid();
    if (!ena) return 1'b0;
    if (m_phase == 0) return q_ul.size() > 0;
    if (m_phase == 2) return q_dl.size() > 0;
    return 1'b0;
  endfunction

  function automatic logic [7:0] m_head();
    if (!m_valid()) return 8'h00;
    return (m_phase == 0) ? q_ul[0] : q_dl[0];
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_phase  = 0;
      m_remain = 1;
      m_len    = 0;
      m_drops  = 0;
      q_ul.delete();
      q_dl.delete();
    end else if (ena) begin
      if (m_valid() && tx_ready) begin
        if (m_phase == 0) void'(q_ul.pop_front());
        else              void'(q_dl.pop_front());
      end
      if (packet_pulse) begin
        if (dir_dl) begin
          if (q_dl.size() < DEPTH) q_dl.push_back(packet_id);
          else if (m_drops < 255) m_drops++;
        end else begin
          if (q_ul.size() < DEPTH) q_ul.push_back(packet_id);
          else if (m_drops < 255) m_drops++;
        end
      end
      m_remain--;
      if (m_remain == 0) begin
        m_phase = (m_phase + 1) % 4;
        if (m_phase % 2 == 0) begin
          m_len    = int'(slot_len);
          m_remain = m_len + 1;
        end else begin
          m_remain = GUARD_CYC;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n && tx_valid && tx_ready && tx_dir_dl) dut_dl_emit.push_back(tx_id);
  end

  function automatic int exp_drops(input int d);
`ifdef ULDL_DROP_CNT_EN
    return d;
`else
    return 0;
`endif
  endfunction

  task automatic check_model(input string tag);
    chk({tag, ".valid"}, tx_valid, m_valid());
    chk({tag, ".id"}, tx_id, m_head());
    chk({tag, ".dir"}, tx_dir_dl, m_phase >= 2);
    chk({tag, ".slot_dl"}, slot_dl, m_phase >= 2);
    chk({tag, ".guard"}, in_guard, m_phase % 2);
    chk({tag, ".ul_count"}, ul_count, q_ul.size());
    chk({tag, ".dl_count"}, dl_count, q_dl.size());
    chk({tag, ".drop"}, drop_cnt, exp_drops(m_drops));
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, ".valid"}, tx_valid, 0);
    chk({tag, ".id"}, tx_id, 0);
    chk({tag, ".dir"}, tx_dir_dl, 0);
    chk({tag, ".slot_dl"}, slot_dl, 0);
    chk({tag, ".guard"}, in_guard, 0);
    chk({tag, ".ul_count"}, ul_count, 0);
    chk({tag, ".dl_count"}, dl_count, 0);
    chk({tag, ".drop"}, drop_cnt, 0);
  endtask

  // One clock: inputs applied just after a rising edge, outputs checked on the falling edge.
  task automatic cyc(input logic en, input logic pul, input logic dr, input logic [7:0] id,
                     input logic rdy, input string tag);
    ena = en; packet_pulse = pul; dir_dl = dr; packet_id = id; tx_ready = rdy;
    @(negedge clk);
    check_model(tag);
    @(posedge clk);
    #1;
  endtask

  task automatic goto_phase(input int ph, input logic rdy);
    int n = 0;
    while (m_phase == ph && n < 64) begin cyc(1, 0, 0, 8'h00, rdy, "wait"); n++; end
    while (m_phase != ph && n < 64) begin cyc(1, 0, 0, 8'h00, rdy, "wait"); n++; end
    chk("goto_phase_timeout", n < 64, 1);
  endtask

  typedef struct {
    logic       en, pul, dr;
    logic [7:0] id;
    logic       rdy;
    logic       v;
    logic [7:0] tid;
    logic       sdl, grd;
    logic [2:0] ul, dl;
  } vec_t;

  function automatic vec_t mk(input logic pul, input logic [7:0] id, input logic v,
                              input logic [7:0] tid, input logic sdl, input logic grd,
                              input logic [2:0] ul);
    vec_t r;
    r.en = 1'b1; r.pul = pul; r.dr = 1'b0; r.id = id; r.rdy = 1'b1;
    r.v = v; r.tid = tid; r.sdl = sdl; r.grd = grd; r.ul = ul; r.dl = 3'd0;
    return r;
  endfunction

  vec_t tbl [12];
  logic [2:0] snap_ul, snap_dl;
  logic [7:0] snap_drop;

  initial begin
    // Reset UL slot is 1 cycle, then guard, 4-cycle DL, guard, 4-cycle UL with slot_len=3.
    tbl[0]  = mk(1, 8'h11, 0, 8'h00, 0, 0, 0);
    tbl[1]  = mk(1, 8'h22, 0, 8'h00, 0, 1, 1);
    tbl[2]  = mk(1, 8'h33, 0, 8'h00, 1, 0, 2);
    tbl[3]  = mk(0, 8'h00, 0, 8'h00, 1, 0, 3);
    tbl[4]  = mk(0, 8'h00, 0, 8'h00, 1, 0, 3);
    tbl[5]  = mk(0, 8'h00, 0, 8'h00, 1, 0, 3);
    tbl[6]  = mk(0, 8'h00, 0, 8'h00, 1, 1, 3);
    tbl[7]  = mk(0, 8'h00, 1, 8'h11, 0, 0, 3);
    tbl[8]  = mk(0, 8'h00, 1, 8'h22, 0, 0, 2);
    tbl[9]  = mk(0, 8'h00, 1, 8'h33, 0, 0, 1);
    tbl[10] = mk(0, 8'h00, 0, 8'h00, 0, 0, 0);
    tbl[11] = mk(0, 8'h00, 0, 8'h00, 0, 1, 0);

    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    rst_n = 1'b1;

    foreach (tbl[i]) begin
      ena = tbl[i].en; packet_pulse = tbl[i].pul; dir_dl = tbl[i].dr;
      packet_id = tbl[i].id; tx_ready = tbl[i].rdy;
      @(negedge clk);
      chk($sformatf("tbl%0d.valid", i), tx_valid, tbl[i].v);
      chk($sformatf("tbl%0d.id", i), tx_id, tbl[i].tid);
      chk($sformatf("tbl%0d.dir", i), tx_dir_dl, tbl[i].sdl);
      chk($sformatf("tbl%0d.slot_dl", i), slot_dl, tbl[i].sdl);
      chk($sformatf("tbl%0d.guard", i), in_guard, tbl[i].grd);
      chk($sformatf("tbl%0d.ul", i), ul_count, tbl[i].ul);
      chk($sformatf("tbl%0d.dl", i), dl_count, tbl[i].dl);
      chk($sformatf("tbl%0d.drop", i), drop_cnt, 0);
      @(posedge clk);
      #1;
    end

    // Six DL pushes into a 4-deep FIFO while nothing drains.
    goto_phase(0, 1'b0);
    cyc(1, 1, 1, 8'h5A, 0, "fill");
    cyc(1, 1, 1, 8'h61, 0, "fill");
    cyc(1, 1, 1, 8'h62, 0, "fill");
    cyc(1, 1, 1, 8'h63, 0, "fill");
    cyc(1, 1, 1, 8'h64, 0, "fill");
    cyc(1, 1, 1, 8'h65, 0, "fill");
    chk("fill.dl_count", dl_count, 4);
    chk("fill.drop", drop_cnt, exp_drops(2));

    // Offer withdrawn at the guard, head retained for the next DL slot.
    goto_phase(3, 1'b0);
    chk("withdraw.valid", tx_valid, 0);
    chk("withdraw.dl_count", dl_count, 4);
    goto_phase(2, 1'b0);
    chk("retry.valid", tx_valid, 1);
    chk("retry.id", tx_id, 8'h5A);

    // Full FIFO push coinciding with a pop is accepted.
    cyc(1, 1, 1, 8'h77, 1, "fullpp");
    chk("fullpp.dl_count", dl_count, 4);
    chk("fullpp.drop", drop_cnt, exp_drops(2));
    for (int n = 0; n < 40 && q_dl.size() != 0; n++) cyc(1, 0, 0, 8'h00, 1, "drain");
    chk("drain.dl_count", dl_count, 0);
    chk("drain.emit_cnt", dut_dl_emit.size(), 5);
    if (dut_dl_emit.size() == 5) begin
      chk("drain.first", dut_dl_emit[0], 8'h5A);
      chk("drain.last", dut_dl_emit[4], 8'h77);
    end

    // ena low mid-slot freezes everything.
    goto_phase(0, 1'b0);
    cyc(1, 1, 0, 8'hA1, 0, "pre");
    cyc(1, 1, 0, 8'hA2, 0, "pre");
    snap_ul = ul_count; snap_dl = dl_count; snap_drop = drop_cnt;
    for (int n = 0; n < 5; n++) begin
      cyc(0, 1, n[0], 8'hC0 + 8'(n), 1, "frz");
      chk("frz.valid", tx_valid, 0);
      chk("frz.ul", ul_count, snap_ul);
      chk("frz.dl", dl_count, snap_dl);
      chk("frz.drop", drop_cnt, snap_drop);
      chk("frz.slot", {slot_dl, in_guard}, 2'b00);
    end
    for (int n = 0; n < 6; n++) cyc(1, 0, 0, 8'h00, 1, "resume");

    // Random traffic; slot_len only changes on the last cycle of a slot longer than one cycle.
    for (int n = 0; n < 400; n++) begin
      if (m_phase % 2 == 0 && m_remain == 1 && m_len > 0) slot_len = 4'($urandom_range(0, 5));
      cyc($urandom_range(0, 9) != 0, $urandom_range(0, 1), $urandom_range(0, 1),
          8'($urandom), $urandom_range(0, 9) < 7, "rnd");
    end

    // Asynchronous reset mid-DL-slot with three DL packets queued.
    ena = 1'b0;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    slot_len = 4'd3;
    cyc(1, 1, 1, 8'hD1, 0, "arst");
    cyc(1, 1, 1, 8'hD2, 0, "arst");
    cyc(1, 1, 1, 8'hD3, 0, "arst");
    goto_phase(2, 1'b0);
    cyc(1, 0, 0, 8'h00, 0, "arst");
    chk("arst.pre_valid", tx_valid, 1);
    chk("arst.pre_dl", dl_count, 3);
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("arst");
    @(posedge clk);
    #1;
    check_reset_outputs("arst_hold");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire
